hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It tracks destination GPRs and CSRs of instructions in flight between decode and writeback. It stalls fetch/decode when a decoding instruction depends on a result not yet written back, and squashes decode on a redirect resolved in execute. It also keeps saturating stall and flush event counters for performance monitoring.

## Interface
Parameters:
- WB_BYPASS, 1: 1 = register file and CSR file are write-before-read, so a result in WB is visible to decode that cycle; 0 = WB entry also counts as a hazard.
- COUNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs1, id_rs2  in  5 each  source register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction reads that source.
- id_rd  in  5  destination register.
- id_reg_write  in  1  instruction writes rd.
- id_csr_write  in  1  instruction is csrrw; it reads and writes a CSR.
- id_csr_addr  in  6  CSR address (instr[25:20]).
- ex_redirect  in  1  taken branch, jal or jalr resolved in EX this cycle.
- stall_if  out  1  hold PC and the IF/ID register.
- stall_id  out  1  hold the decode instruction.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_id  out  1  squash the IF/ID contents.
- stall_count  out  COUNT_W  cycles with stall_id=1, saturating.
- flush_count  out  COUNT_W  cycles with flush_id=1, saturating.

## Operation
- In-flight tracker: one entry per stage EX, MEM, WB. Each entry holds {valid, rd, reg_write, csr_write, csr_addr}. Stages EX, MEM and WB never stall, so the tracker shifts every cycle.
- Checked entries: EX and MEM when WB_BYPASS=1; EX, MEM and WB when WB_BYPASS=0.
- GPR hazard on a source s (rs1 or rs2):
  - use_s=1 and s≠0; and
  - some checked entry has valid=1, reg_write=1 and rd==s.
  - rd==x0 never creates a hazard.
- CSR hazard:
  - id_csr_write=1; and
  - some checked entry has valid=1, csr_write=1 and csr_addr==id_csr_addr.
- hazard = id_valid AND (GPR hazard on rs1 OR GPR hazard on rs2 OR CSR hazard).
- Outputs are combinational from the current entries and inputs:
  - flush_id = ex_redirect.
  - stall_if = stall_id = hazard AND NOT ex_redirect. A redirect wins over a stall because the dependent instruction is being squashed.
  - bubble_ex = hazard OR ex_redirect.
- Tracker update at each clock edge:
  - WB ← MEM, MEM ← EX.
  - EX ← decode fields with valid = id_valid AND NOT bubble_ex; otherwise EX ← invalid.
- Counters:
  - stall_count += 1 on each cycle with stall_id=1.
  - flush_count += 1 on each cycle with flush_id=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset:
  - While reset=1, all outputs are forced to 0 combinationally.
  - At the edge with reset=1, all entries are cleared to invalid and both counters are cleared to 0.
  - A reset in mid-stall releases the stall immediately; no pending hazard survives reset.
- Stall length with WB_BYPASS=1:
  - Producer issued one cycle before the consumer: 2 stall cycles.
  - Producer two cycles ahead: 1 stall cycle.
  - Producer three or more cycles ahead: 0 stall cycles.
- With WB_BYPASS=0, each of the above is one cycle longer (3/2/1/0).
- Inputs are sampled in the same cycle; latency from an input change to the outputs is 0 cycles; tracker latency is 1 cycle.
- id_valid=0 produces no hazard and enters an invalid EX entry.
- Both sources can hit different entries; the stall persists until the last matching entry leaves the checked set.
- ex_redirect together with a hazard: flush_id=1, bubble_ex=1, stall_if=stall_id=0, and stall_count does not increment.

## Test plan
- Reset for 2 cycles with arbitrary inputs -> all outputs 0 during reset; after release, stall_count=0 and flush_count=0.
- WB_BYPASS=1: issue addi x5,x0,1, then decode add x6,x5,x1 in the next cycle -> stall_id=1 for exactly 2 cycles, bubble_ex=1 in those cycles, released on cycle 3; stall_count=2. Repeat with WB_BYPASS=0 -> 3 stall cycles, stall_count=3.
- Producer with rd=x0, consumer reading x0 -> no stall. Consumer with id_use_rs2=0 and rs2 matching an in-flight rd -> no stall.
- Dependent add in decode while ex_redirect=1 -> flush_id=1, bubble_ex=1, stall_id=0, flush_count increments by 1, stall_count unchanged.
- Back-to-back csrrw to CSR address 6'h05 -> 2 stall cycles. csrrw to 6'h05 followed by csrrw to 6'h06 -> no stall.
- COUNT_W=4 with a forced hazard held for 20 cycles -> stall_count reaches 15 and stays at 15. Assert reset mid-stall -> stall_id=0 in the same cycle and counters 0 after the edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I pipeline hazard controller.
// Ports: clk, reset (sync, active-high); decode fields id_*; ex_redirect;
//   stall_if/stall_id/bubble_ex/flush_id controls; stall_count/flush_count
//   saturating event counters (COUNT_W bits).
module hazard_ctrl #(
    parameter int WB_BYPASS = 1,
    parameter int COUNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic               id_use_rs1,
    input  logic               id_use_rs2,
    input  logic [4:0]         id_rd,
    input  logic               id_reg_write,
    input  logic               id_csr_write,
    input  logic [5:0]         id_csr_addr,
    input  logic               ex_redirect,
    output logic               stall_if,
    output logic               stall_id,
    output logic               bubble_ex,
    output logic               flush_id,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       csr_write;
        logic [5:0] csr_addr;
    } entry_t;

    entry_t ex_q, mem_q, wb_q;
    entry_t ex_d;

    logic [COUNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [COUNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hit_ex, hit_mem, hit_wb;
    logic hazard;
    logic stall_raw, bubble_raw;

    // A source only matters when it is actually read and is not x0.
    function automatic logic src_hit(entry_t e, logic [4:0] s, logic use_s);
        return use_s && (s != 5'd0) && e.valid && e.reg_write && (e.rd == s);
    endfunction

    function automatic logic entry_hit(entry_t e);
        logic csr_hit;
        csr_hit = id_csr_write && e.valid && e.csr_write
                  && (e.csr_addr == id_csr_addr);
        return src_hit(e, id_rs1, id_use_rs1)
            || src_hit(e, id_rs2, id_use_rs2)
            || csr_hit;
    endfunction

    always_comb begin
        hit_ex  = entry_hit(ex_q);
        hit_mem = entry_hit(mem_q);
        // With write-before-read files the WB result is already visible.
        hit_wb  = (WB_BYPASS == 0) ? entry_hit(wb_q) : 1'b0;
        hazard  = id_valid && (hit_ex || hit_mem || hit_wb);

        // A redirect squashes the dependent instruction, so it beats a stall.
        stall_raw  = hazard && !ex_redirect;
        bubble_raw = hazard || ex_redirect;
    end

    always_comb begin
        ex_d.valid     = id_valid && !bubble_raw;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.csr_write = id_csr_write;
        ex_d.csr_addr  = id_csr_addr;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_raw && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + COUNT_W'(1);
        end
        if (ex_redirect && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset forces every output low in the same cycle.
    always_comb begin
        stall_if    = !reset && stall_raw;
        stall_id    = !reset && stall_raw;
        bubble_ex   = !reset && bubble_raw;
        flush_id    = !reset && ex_redirect;
        stall_count = reset ? '0 : stall_cnt_q;
        flush_count = reset ? '0 : flush_cnt_q;
    end

endmodule
